// File: rtl/rsp_idx_router_pkg.sv
// -----------------------------------------------------------------------------
// rsp_idx_router_pkg
// Shared helper for the response index router and its tracking FIFO.
// Contents:
//   safe_clog2(n) : ceil(log2(n)) clamped to a minimum of 1, so that a single
//                   destination or a single-entry FIFO still gets a 1-bit field.
// -----------------------------------------------------------------------------
package rsp_idx_router_pkg;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/rsp_idx_fifo.sv
// -----------------------------------------------------------------------------
// rsp_idx_fifo
// In-order FIFO of destination indices for outstanding requests.
// Ports:
//   clk_i, rst_ni : clock (posedge) and asynchronous active-low reset
//   flush_i       : synchronous clear of pointers and count
//   push_i/data_i : enqueue request (ignored while full)
//   pop_i         : dequeue head (ignored while empty)
//   full_o        : registered, Depth entries outstanding
//   cnt_o         : registered occupancy
//   head_o        : index at the head, '0 when empty
// When StoreIdx is 0 only the occupancy counter exists and head_o is '0.
// -----------------------------------------------------------------------------
module rsp_idx_fifo
  import rsp_idx_router_pkg::*;
#(
  parameter int unsigned Depth    = 8,
  parameter int unsigned Width    = 1,
  parameter bit          StoreIdx = 1'b1,
  parameter int unsigned CntWidth = $clog2(Depth + 32'd1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [Width-1:0]    data_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic [CntWidth-1:0] cnt_o,
  output logic [Width-1:0]    head_o
);

  localparam int unsigned         PtrWidth = safe_clog2(Depth);
  localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 32'd1);
  localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(Depth);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                full_q, full_d;
  logic                push_s, pop_s;

  assign push_s = push_i && !full_q;
  assign pop_s  = pop_i && (cnt_q != '0);

  // Occupancy next state; flush overrides any same-cycle push or pop.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CntWidth'(1);
        2'b01:   cnt_d = cnt_q - CntWidth'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // full is precomputed from the next count so the output is a plain flop.
  assign full_d = (cnt_d == MaxCnt);

  // Occupancy and full registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign full_o = full_q;

  if (StoreIdx) begin : g_store
    logic [PtrWidth-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [Width-1:0]    mem_q [Depth];

    // Pointer next state; wrap by explicit compare so Depth need not be 2^n.
    always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush_i) begin
        wr_d = '0;
        rd_d = '0;
      end else begin
        if (push_s) begin
          wr_d = (wr_q == LastPtr) ? '0 : wr_q + PtrWidth'(1);
        end else begin
          wr_d = wr_q;
        end
        if (pop_s) begin
          rd_d = (rd_q == LastPtr) ? '0 : rd_q + PtrWidth'(1);
        end else begin
          rd_d = rd_q;
        end
      end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        wr_q <= wr_d;
        rd_q <= rd_d;
      end
    end

    // Index storage; written only on an accepted, non-flushed push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(Depth); i++) begin
          mem_q[i] <= '0;
        end
      end else if (push_s && !flush_i) begin
        mem_q[wr_q] <= data_i;
      end
    end

    // Head comes from registers only: a push is visible one cycle later.
    assign head_o = (cnt_q != '0) ? mem_q[rd_q] : '0;
  end else begin : g_no_store
    assign head_o = '0;
  end

endmodule

// File: rtl/rsp_idx_router.sv
// -----------------------------------------------------------------------------
// rsp_idx_router
// Steers the single in-order response stream of a slave back to the arbiter
// input that issued the matching request.
// Ports:
//   clk_i, rst_ni            : clock (posedge), asynchronous active-low reset
//   flush_i                  : synchronous clear of tracking state and error flag
//   req_push_i, req_idx_i    : accepted request and its winning arbiter index
//   full_o                   : registered; gate the arbiter grant with ~full_o
//   rsp_valid_i/ready_o/data_i : response from the slave
//   rsp_valid_o/ready_i      : per-destination handshake (valid one-hot or zero)
//   rsp_data_o               : payload broadcast to every destination
//   rsp_idx_o                : head index, '0 when nothing is outstanding
//   cnt_o                    : registered outstanding count
//   spurious_o               : sticky, response seen with nothing outstanding
// -----------------------------------------------------------------------------
module rsp_idx_router
  import rsp_idx_router_pkg::*;
#(
  parameter int unsigned NumOut    = 64,
  parameter int unsigned DataWidth = 32,
  parameter type         DataType  = logic [DataWidth-1:0],
  parameter int unsigned MaxTxns   = 8,
  parameter int unsigned IdxWidth  = safe_clog2(NumOut),
  parameter type         idx_t     = logic [IdxWidth-1:0],
  parameter int unsigned CntWidth  = $clog2(MaxTxns + 32'd1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                req_push_i,
  input  idx_t                req_idx_i,
  output logic                full_o,
  input  logic                rsp_valid_i,
  output logic                rsp_ready_o,
  input  DataType             rsp_data_i,
  output logic [NumOut-1:0]   rsp_valid_o,
  input  logic [NumOut-1:0]   rsp_ready_i,
  output DataType             rsp_data_o,
  output idx_t                rsp_idx_o,
  output logic [CntWidth-1:0] cnt_o,
  output logic                spurious_o
);

  idx_t head_s;
  logic pop_s;
  logic empty_s;
  logic spurious_q, spurious_d;

  rsp_idx_fifo #(
    .Depth    (MaxTxns),
    .Width    (IdxWidth),
    .StoreIdx (NumOut > 32'd1),
    .CntWidth (CntWidth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (req_push_i),
    .data_i  (req_idx_i),
    .pop_i   (pop_s),
    .full_o  (full_o),
    .cnt_o   (cnt_o),
    .head_o  (head_s)
  );

  assign empty_s = (cnt_o == '0);

  // Head-index decode to one-hot valid and the matching ready mux.
  always_comb begin
    rsp_valid_o = '0;
    rsp_ready_o = 1'b0;
    if (!empty_s) begin
      for (int i = 0; i < int'(NumOut); i++) begin
        if (head_s == idx_t'(i)) begin
          rsp_valid_o[i] = rsp_valid_i;
          rsp_ready_o    = rsp_ready_i[i];
        end else begin
          rsp_valid_o[i] = 1'b0;
        end
      end
    end else begin
      rsp_valid_o = '0;
      rsp_ready_o = 1'b0;
    end
  end

  // rsp_ready_o is already zero when empty, so no extra guard is needed.
  assign pop_s = rsp_valid_i && rsp_ready_o;

  // Sticky error flag next state; flush wins over a same-cycle set.
  always_comb begin
    spurious_d = spurious_q;
    if (flush_i) begin
      spurious_d = 1'b0;
    end else if (rsp_valid_i && empty_s) begin
      spurious_d = 1'b1;
    end else begin
      spurious_d = spurious_q;
    end
  end

  // Sticky error flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spurious_q <= 1'b0;
    end else begin
      spurious_q <= spurious_d;
    end
  end

  assign spurious_o = spurious_q;
  assign rsp_idx_o  = head_s;
  assign rsp_data_o = rsp_data_i;

endmodule
